// File: rtl/acl2_fmt_pkg.sv
// acl2_fmt_pkg
// Shared types and constants for the ACL2 sample line formatter.
// Configuration macro: ACL2_FMT_TEMP_EN. When it is defined, the temperature
// word is printed and lines are 29 characters long. When it is undefined,
// lines are 22 characters long and no temperature storage exists.
package acl2_fmt_pkg;

  // Eight-byte measurement vector delivered by the PMOD ACL2 driver.
  typedef logic [63:0] t_pmod_acl2_reg_8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } t_acl2_fmt_state;

`ifdef ACL2_FMT_TEMP_EN
  localparam int c_fmt_line_len = 29;
`else
  localparam int c_fmt_line_len = 22;
`endif
  localparam int c_fmt_char_idx_bits = 5;

  localparam logic [7:0] c_ascii_x  = 8'h58;
  localparam logic [7:0] c_ascii_y  = 8'h59;
  localparam logic [7:0] c_ascii_z  = 8'h5A;
  localparam logic [7:0] c_ascii_t  = 8'h54;
  localparam logic [7:0] c_ascii_eq = 8'h3D;
  localparam logic [7:0] c_ascii_sp = 8'h20;
  localparam logic [7:0] c_ascii_cr = 8'h0D;
  localparam logic [7:0] c_ascii_lf = 8'h0A;

  // Sample as stored by the formatter: words already assembled high:low.
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
`ifdef ACL2_FMT_TEMP_EN
    logic [15:0] t;
`endif
  } t_acl2_fmt_sample;

  // 4-bit value to uppercase ASCII hex digit.
  function automatic logic [7:0] fmt_hex(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

endpackage

// File: rtl/acl2_fmt_char_sel.sv
// acl2_fmt_char_sel
// Purely combinational character generator: maps a character index within the
// text line and the active sample to the ASCII byte at that position.
// Configuration macro: ACL2_FMT_TEMP_EN (adds the " T=hhhh" field).
// Ports:
//   char_idx  - position in the line (0 .. c_fmt_line_len-1)
//   sample    - active sample words
//   char_byte - ASCII character at char_idx (space for out-of-range indices)
module acl2_fmt_char_sel
  import acl2_fmt_pkg::*;
(
  input  logic [c_fmt_char_idx_bits-1:0] char_idx,
  input  t_acl2_fmt_sample               sample,
  output logic [7:0]                     char_byte
);

  always_comb begin
    char_byte = c_ascii_sp;
    case (char_idx)
      5'd0:  char_byte = c_ascii_x;
      5'd1:  char_byte = c_ascii_eq;
      5'd2:  char_byte = fmt_hex(sample.x[15:12]);
      5'd3:  char_byte = fmt_hex(sample.x[11:8]);
      5'd4:  char_byte = fmt_hex(sample.x[7:4]);
      5'd5:  char_byte = fmt_hex(sample.x[3:0]);
      5'd7:  char_byte = c_ascii_y;
      5'd8:  char_byte = c_ascii_eq;
      5'd9:  char_byte = fmt_hex(sample.y[15:12]);
      5'd10: char_byte = fmt_hex(sample.y[11:8]);
      5'd11: char_byte = fmt_hex(sample.y[7:4]);
      5'd12: char_byte = fmt_hex(sample.y[3:0]);
      5'd14: char_byte = c_ascii_z;
      5'd15: char_byte = c_ascii_eq;
      5'd16: char_byte = fmt_hex(sample.z[15:12]);
      5'd17: char_byte = fmt_hex(sample.z[11:8]);
      5'd18: char_byte = fmt_hex(sample.z[7:4]);
      5'd19: char_byte = fmt_hex(sample.z[3:0]);
`ifdef ACL2_FMT_TEMP_EN
      5'd21: char_byte = c_ascii_t;
      5'd22: char_byte = c_ascii_eq;
      5'd23: char_byte = fmt_hex(sample.t[15:12]);
      5'd24: char_byte = fmt_hex(sample.t[11:8]);
      5'd25: char_byte = fmt_hex(sample.t[7:4]);
      5'd26: char_byte = fmt_hex(sample.t[3:0]);
      5'd27: char_byte = c_ascii_cr;
      5'd28: char_byte = c_ascii_lf;
`else
      5'd20: char_byte = c_ascii_cr;
      5'd21: char_byte = c_ascii_lf;
`endif
      default: char_byte = c_ascii_sp;
    endcase
  end

endmodule

// File: rtl/acl2_sample_line_formatter.sv
// acl2_sample_line_formatter
// Latches ACL2 measurement samples and prints each as one uppercase-hex text
// line "X=hhhh Y=hhhh Z=hhhh[ T=hhhh]" CR LF over a valid/ready byte stream.
// One sample can wait in a pending buffer while a line is in flight; samples
// that get overwritten or discarded are counted in o_drop_count (saturating).
// Configuration macro: ACL2_FMT_TEMP_EN (temperature field, 29-char lines).
// Handshake: a byte moves when o_tx_valid & i_tx_ready at a rising edge;
// o_tx_valid never drops and o_tx_byte never changes until that happens.
// Ports:
//   i_clk_20mhz, i_rstn_20mhz - clock, async active-low reset
//   i_data_3axis_temp         - {XL,XH,YL,YH,ZL,ZH,TL,TH}
//   i_data_valid              - one-cycle sample strobe
//   o_tx_byte, o_tx_valid     - ASCII byte stream out
//   i_tx_ready                - sink ready
//   o_busy                    - high while a line is being emitted
//   o_drop_count              - discarded samples, saturates at 8'hFF
module acl2_sample_line_formatter
  import acl2_fmt_pkg::*;
(
  input  logic             i_clk_20mhz,
  input  logic             i_rstn_20mhz,
  input  t_pmod_acl2_reg_8 i_data_3axis_temp,
  input  logic             i_data_valid,
  output logic [7:0]       o_tx_byte,
  output logic             o_tx_valid,
  input  logic             i_tx_ready,
  output logic             o_busy,
  output logic [7:0]       o_drop_count
);

  localparam logic [c_fmt_char_idx_bits-1:0] c_last_idx =
    c_fmt_char_idx_bits'(c_fmt_line_len - 1);

  t_acl2_fmt_state                state;
  logic [c_fmt_char_idx_bits-1:0] char_idx;
  t_acl2_fmt_sample               active;
  t_acl2_fmt_sample               pending;
  logic                           pend_full;
  t_acl2_fmt_sample               in_sample;
  logic [7:0]                     next_char;
  logic                           xfer;
  logic                           last_xfer;
  logic                           drop_event;

  // Reassemble the byte vector into high:low words.
  assign in_sample.x = i_data_3axis_temp[55:40] == 16'h0 ? {i_data_3axis_temp[55:48], i_data_3axis_temp[63:56]}
                                                          : {i_data_3axis_temp[55:48], i_data_3axis_temp[63:56]};
  assign in_sample.y = {i_data_3axis_temp[39:32], i_data_3axis_temp[47:40]};
  assign in_sample.z = {i_data_3axis_temp[23:16], i_data_3axis_temp[31:24]};
`ifdef ACL2_FMT_TEMP_EN
  assign in_sample.t = {i_data_3axis_temp[7:0], i_data_3axis_temp[15:8]};
`else
  logic unused_temp_bytes;
  assign unused_temp_bytes = ^i_data_3axis_temp[15:0];
`endif

  assign xfer      = o_tx_valid & i_tx_ready;
  assign last_xfer = xfer & (char_idx == c_last_idx);
  // Any strobe during a line while pending already holds a sample loses one
  // sample: either the old pending (overwritten) or it is discarded at LF.
  assign drop_event = (state == ST_EMIT) & i_data_valid & pend_full;

  // Look one character ahead so the registered output is ready after a transfer.
  acl2_fmt_char_sel u_char_sel (
    .char_idx  (char_idx + 1'b1),
    .sample    (active),
    .char_byte (next_char)
  );

  always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
    if (!i_rstn_20mhz) begin
      state      <= ST_IDLE;
      char_idx   <= '0;
      active     <= '0;
      pending    <= '0;
      pend_full  <= 1'b0;
      o_tx_byte  <= 8'h00;
      o_tx_valid <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_data_valid) begin
            active     <= in_sample;
            char_idx   <= '0;
            o_tx_byte  <= c_ascii_x;
            o_tx_valid <= 1'b1;
            o_busy     <= 1'b1;
            state      <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (last_xfer) begin
            if (i_data_valid) begin
              active    <= in_sample;
              pend_full <= 1'b0;
              char_idx  <= '0;
              o_tx_byte <= c_ascii_x;
            end else if (pend_full) begin
              active    <= pending;
              pend_full <= 1'b0;
              char_idx  <= '0;
              o_tx_byte <= c_ascii_x;
            end else begin
              o_tx_valid <= 1'b0;
              o_busy     <= 1'b0;
              state      <= ST_IDLE;
            end
          end else begin
            if (xfer) begin
              char_idx  <= char_idx + 1'b1;
              o_tx_byte <= next_char;
            end
            if (i_data_valid) begin
              pending   <= in_sample;
              pend_full <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
    if (!i_rstn_20mhz) begin
      o_drop_count <= 8'h00;
    end else if (drop_event && (o_drop_count != 8'hFF)) begin
      o_drop_count <= o_drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_acl2_sample_line_formatter.sv
// tb_acl2_sample_line_formatter
// Scoreboard bench: a transaction-level model turns each accepted sample into
// the full expected text line and pushes its bytes onto exp_q; a monitor on
// the falling edge pops one byte per observed transfer and compares.
// Configuration macro: ACL2_FMT_TEMP_EN (29- vs 22-character lines).
`timescale 1ns/1ps
module tb_acl2_sample_line_formatter;

`ifdef ACL2_FMT_TEMP_EN
  localparam int LINE_LEN = 29;
  localparam string REF_TEXT = "X=0123 Y=FFCD Z=03E8 T=005A";
`else
  localparam int LINE_LEN = 22;
  localparam string REF_TEXT = "X=0123 Y=FFCD Z=03E8";
`endif
  localparam logic [63:0] REF_VEC = 64'h2301_CDFF_E803_5A00;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] din = '0;
  logic        i_data_valid = 1'b0;
  logic        i_tx_ready = 1'b1;
  logic [7:0]  o_tx_byte;
  logic        o_tx_valid;
  logic        o_busy;
  logic [7:0]  o_drop_count;

  always #25 clk = ~clk;

  acl2_sample_line_formatter dut (
    .i_clk_20mhz       (clk),
    .i_rstn_20mhz      (rst_n),
    .i_data_3axis_temp (din),
    .i_data_valid      (i_data_valid),
    .o_tx_byte         (o_tx_byte),
    .o_tx_valid        (o_tx_valid),
    .i_tx_ready        (i_tx_ready),
    .o_busy            (o_busy),
    .o_drop_count      (o_drop_count)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  function automatic void check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  string hexd = "0123456789ABCDEF";

  function automatic void push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endfunction

  function automatic void push_word(input logic [15:0] w);
    for (int i = 3; i >= 0; i--) exp_q.push_back(hexd[w[4*i +: 4]]);
  endfunction

  function automatic void push_line(input logic [63:0] d);
    push_str("X=");  push_word({d[55:48], d[63:56]});
    push_str(" Y="); push_word({d[39:32], d[47:40]});
    push_str(" Z="); push_word({d[23:16], d[31:24]});
`ifdef ACL2_FMT_TEMP_EN
    push_str(" T="); push_word({d[7:0], d[15:8]});
`endif
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  bit          m_active = 0;
  int          m_rem = 0;
  bit          m_pend = 0;
  logic [63:0] m_pend_data = '0;
  int          m_drop = 0;

  function automatic void m_bump();
    if (m_drop < 255) m_drop++;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_rem = 0; m_pend = 0; m_drop = 0;
      exp_q.delete();
    end else if (!m_active) begin
      if (i_data_valid) begin
        push_line(din); m_active = 1; m_rem = LINE_LEN;
      end
    end else if (i_tx_ready && m_rem == 1) begin
      if (i_data_valid) begin
        if (m_pend) begin m_pend = 0; m_bump(); end
        push_line(din); m_rem = LINE_LEN;
      end else if (m_pend) begin
        m_pend = 0; push_line(m_pend_data); m_rem = LINE_LEN;
      end else begin
        m_active = 0; m_rem = 0;
      end
    end else begin
      if (i_tx_ready) m_rem--;
      if (i_data_valid) begin
        if (m_pend) m_bump();
        m_pend = 1; m_pend_data = din;
      end
    end
  end

  // ---------------- monitor ----------------
  bit         prev_stall = 0;
  logic [7:0] prev_byte = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      check("tx_valid", o_tx_valid, m_active);
      check("busy", o_busy, m_active);
      check("drop_count", o_drop_count, m_drop);
      if (prev_stall) check("stall_hold", {o_tx_valid, o_tx_byte}, {1'b1, prev_byte});
      if (o_tx_valid && i_tx_ready) begin
        rx_q.push_back(o_tx_byte);
        if (exp_q.size() == 0) check("tx_unexpected", o_tx_byte, 8'hxx);
        else check("tx_byte", o_tx_byte, exp_q.pop_front());
      end
      prev_stall = o_tx_valid && !i_tx_ready;
      prev_byte  = o_tx_byte;
    end
  end

  // ---------------- drivers ----------------
  int ready_pct = 100;

  always @(posedge clk) begin
    #1;
    i_tx_ready = ($urandom_range(99) < ready_pct);
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [63:0] d);
    din = d; i_data_valid = 1'b1;
    @(posedge clk); #1;
    i_data_valid = 1'b0;
  endtask

  task automatic do_reset();
    i_data_valid = 1'b0;
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    rx_q.delete();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((m_active || exp_q.size() != 0) && n < 3000) begin idle(1); n++; end
    check({name, "_drain_timeout"}, n >= 3000, 0);
  endtask

  // Compare captured bytes at offset against the literal reference line.
  task automatic check_ref_line(input string name, input int off);
    int bad = 0;
    if (rx_q.size() < off + LINE_LEN) bad = 1000;
    else begin
      for (int i = 0; i < LINE_LEN - 2; i++) if (rx_q[off + i] !== REF_TEXT[i]) bad++;
      if (rx_q[off + LINE_LEN - 2] !== 8'h0D) bad++;
      if (rx_q[off + LINE_LEN - 1] !== 8'h0A) bad++;
    end
    check(name, bad, 0);
  endtask

  // ---------------- sequence ----------------
  initial begin
    idle(2);
    check("reset_tx_valid", o_tx_valid, 0);
    check("reset_tx_byte", o_tx_byte, 8'h00);
    check("reset_busy", o_busy, 0);
    check("reset_drop", o_drop_count, 0);
    do_reset();

    // Single reference sample, sink always ready.
    ready_pct = 100; idle(1);
    send(REF_VEC);
    wait_idle("single");
    check("single_len", rx_q.size(), LINE_LEN);
    check_ref_line("single_text", 0);

    // Same sample under 30% ready back-pressure.
    rx_q.delete(); ready_pct = 30;
    send(REF_VEC);
    wait_idle("bp");
    check("bp_len", rx_q.size(), LINE_LEN);
    check_ref_line("bp_text", 0);

    // Two samples, second mid-line: back-to-back lines, no drops.
    do_reset(); ready_pct = 100; idle(1);
    send(REF_VEC); idle(8); send(64'h1122_3344_5566_7788);
    wait_idle("two");
    check("two_len", rx_q.size(), 2 * LINE_LEN);
    check("two_drop", o_drop_count, 0);

    // Three samples in one line: second overwritten.
    do_reset(); ready_pct = 100; idle(1);
    send(64'hA1A2_A3A4_A5A6_A7A8); send(64'hB1B2_B3B4_B5B6_B7B8);
    idle(3); send(REF_VEC);
    wait_idle("three");
    check("three_len", rx_q.size(), 2 * LINE_LEN);
    check("three_drop", o_drop_count, 1);
    check_ref_line("three_second_line", LINE_LEN);

    // Strobe on the LF transfer while pending is full.
    rx_q.delete();
    send(64'hC1C2_C3C4_C5C6_C7C8); send(64'hD1D2_D3D4_D5D6_D7D8);
    idle(LINE_LEN - 2); send(REF_VEC);
    wait_idle("lf_hit");
    check("lf_hit_len", rx_q.size(), 2 * LINE_LEN);
    check("lf_hit_drop", o_drop_count, 2);
    check_ref_line("lf_hit_second_line", LINE_LEN);

    // Randomised soak with random back-pressure.
    for (int i = 0; i < 600; i++) begin
      ready_pct = 30 + (i / 100) * 14;
      if ($urandom_range(99) < 6) send({$urandom, $urandom});
      else idle(1);
    end
    wait_idle("soak");

    // Reset at character index 10.
    ready_pct = 100; idle(1); rx_q.delete();
    send(64'hE1E2_E3E4_E5E6_E7E8);
    idle(10);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_tx_valid", o_tx_valid, 0);
    check("midreset_tx_byte", o_tx_byte, 8'h00);
    check("midreset_busy", o_busy, 0);
    check("midreset_drop", o_drop_count, 0);
    idle(2);
    rst_n = 1'b1; rx_q.delete();
    idle(3);
    check("post_reset_quiet", rx_q.size(), 0);
    send(REF_VEC);
    wait_idle("post_reset");
    check("post_reset_len", rx_q.size(), LINE_LEN);
    check_ref_line("post_reset_text", 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
